// File: rtl/sp6_frame_align_pkg.sv
// Shared definitions for the Spartan-6 ISERDES word aligner: state encoding
// and the slip-count width/saturation helper.
package sp6_frame_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    localparam int SLIP_W = 5;
    localparam logic [SLIP_W-1:0] SLIP_SAT = '1;

    function automatic logic [SLIP_W-1:0] sat_inc(input logic [SLIP_W-1:0] v);
        return (v == SLIP_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sp6_frame_align_if.sv
// Aligner-facing bundle: control levels, receiver word in, bitslip and the
// aligned word/status out.
interface sp6_frame_align_if #(parameter int DW = 8);

    logic                                   enable;
    logic                                   restart;
    logic [DW-1:0]                          data_in;
    logic                                   bitslip;
    logic                                   aligned;
    logic                                   fail;
    logic [sp6_frame_align_pkg::SLIP_W-1:0] slip_count;
    logic [DW-1:0]                          data_out;
    logic                                   data_valid;

    modport master (
        output enable, restart, data_in,
        input  bitslip, aligned, fail, slip_count, data_out, data_valid
    );

    modport slave (
        input  enable, restart, data_in,
        output bitslip, aligned, fail, slip_count, data_out, data_valid
    );

endinterface

// File: rtl/sp6_match_counter.sv
// Saturating consecutive-event counter; hit flags the event that reaches LIMIT
// so the caller can act in the same cycle.
module sp6_match_counter #(
    parameter int LIMIT = 8,
    localparam int W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] TOP  = W'(LIMIT);

    logic [W-1:0] count;

    assign hit = inc && !clr && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (inc && count != TOP)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/sp6_frame_align.sv
// Hunts for the ADC training word by pulsing the ISERDES bitslip, declares
// lock after consecutive matches and re-hunts on sustained loss of lock.
module sp6_frame_align
    import sp6_frame_align_pkg::*;
#(
    parameter int            DW            = 8,
    parameter logic [DW-1:0] PATTERN       = DW'(8'hF0),
    parameter int            SETTLE_CYCLES = 4,
    parameter int            LOCK_COUNT    = 8,
    parameter int            UNLOCK_COUNT  = 4,
    parameter int            MAX_SLIPS     = 15
) (
    input logic             sample_clk,
    input logic             reset,
    sp6_frame_align_if.slave bus
);

    localparam int                SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [SLIP_W-1:0] SLIP_MAX    = SLIP_W'(MAX_SLIPS);

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic          match;
    logic          go_idle;
    logic          go_restart;
    logic          lock_hit;
    logic          unlock_hit;

    assign match      = (bus.data_in == PATTERN);
    assign go_idle    = !bus.enable;
    assign go_restart = bus.enable && bus.restart && (state != ST_IDLE);

    sp6_match_counter #(.LIMIT(LOCK_COUNT)) u_lock_cnt (
        .clk   (sample_clk),
        .reset (reset),
        .clr   (go_idle || go_restart || state != ST_CHECK),
        .inc   (state == ST_CHECK && match),
        .hit   (lock_hit)
    );

    // Any match while locked breaks the run, so only consecutive misses unlock.
    sp6_match_counter #(.LIMIT(UNLOCK_COUNT)) u_unlock_cnt (
        .clk   (sample_clk),
        .reset (reset),
        .clr   (go_idle || go_restart || state != ST_LOCKED || match),
        .inc   (state == ST_LOCKED && !match),
        .hit   (unlock_hit)
    );

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            bus.bitslip    <= 1'b0;
            bus.aligned    <= 1'b0;
            bus.fail       <= 1'b0;
            bus.slip_count <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
        end else begin
            bus.data_out <= bus.data_in;
            bus.bitslip  <= 1'b0;
            if (go_idle) begin
                state          <= ST_IDLE;
                settle_cnt     <= '0;
                bus.aligned    <= 1'b0;
                bus.fail       <= 1'b0;
                bus.slip_count <= '0;
                bus.data_valid <= 1'b0;
            end else if (go_restart) begin
                // A bitslip already on the wire finishes; the SETTLE wait absorbs it.
                state          <= ST_SETTLE;
                settle_cnt     <= '0;
                bus.aligned    <= 1'b0;
                bus.fail       <= 1'b0;
                bus.slip_count <= '0;
                bus.data_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state          <= ST_SETTLE;
                        settle_cnt     <= '0;
                        bus.slip_count <= '0;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST)
                            state <= ST_CHECK;
                        else
                            settle_cnt <= settle_cnt + 1'b1;
                    end
                    ST_CHECK: begin
                        if (match) begin
                            if (lock_hit) begin
                                state          <= ST_LOCKED;
                                bus.aligned    <= 1'b1;
                                bus.data_valid <= 1'b1;
                            end
                        end else if (bus.slip_count >= SLIP_MAX) begin
                            state    <= ST_FAIL;
                            bus.fail <= 1'b1;
                        end else begin
                            state          <= ST_SLIP;
                            bus.bitslip    <= 1'b1;
                            bus.slip_count <= sat_inc(bus.slip_count);
                        end
                    end
                    ST_SLIP: begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                    ST_LOCKED: begin
                        // Re-hunt keeps slip_count; CHECK decides whether to slip.
                        if (unlock_hit) begin
                            state          <= ST_SETTLE;
                            settle_cnt     <= '0;
                            bus.aligned    <= 1'b0;
                            bus.data_valid <= 1'b0;
                        end
                    end
                    ST_FAIL: state <= ST_FAIL;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sp6_frame_align.sv
// Self-checking bench: rotating-source ISERDES model, table and random hunts
// against a timeline model, plus hand sequences for fail/unlock/reset/enable.
module tb_sp6_frame_align;
    import sp6_frame_align_pkg::*;

    localparam logic [7:0] PAT = 8'hF0;

    typedef struct {
        int rot;
        int exp_slips;
        int exp_lock;
    } vec_t;

    logic sample_clk = 1'b0;
    logic reset      = 1'b1;
    always #5 sample_clk = ~sample_clk;

    sp6_frame_align_if #(.DW(8)) bus();

    sp6_frame_align #(
        .DW(8), .PATTERN(8'hF0), .SETTLE_CYCLES(4), .LOCK_COUNT(8),
        .UNLOCK_COUNT(4), .MAX_SLIPS(15)
    ) dut (
        .sample_clk (sample_clk),
        .reset      (reset),
        .bus        (bus)
    );

    // Receiver model: raw word rotated one position per bitslip seen.
    logic [7:0] raw       = PAT;
    logic       inject    = 1'b0;
    logic       src_zero  = 1'b0;
    logic       model_clr = 1'b1;
    int         nslips    = 0;
    int         pulses    = 0;
    int         b2b       = 0;
    logic       prev_bs   = 1'b0;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        logic [15:0] t;
        t = {x, x} << (k % 8);
        return t[15:8];
    endfunction

    assign bus.data_in = src_zero ? 8'h00 : (inject ? 8'h0F : rotl8(raw, nslips));

    always @(posedge sample_clk) begin
        if (model_clr) nslips <= 0;
        else if (bus.bitslip) nslips <= nslips + 1;
        if (bus.bitslip) pulses <= pulses + 1;
        if (bus.bitslip && prev_bs) b2b <= b2b + 1;
        prev_bs <= bus.bitslip;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic obs();
        @(negedge sample_clk);
    endtask

    // Leaves the bench in cycle 0 with enable driven high.
    task automatic start_hunt(input logic [7:0] src_raw, input logic zero);
        reset = 1'b1; bus.enable = 1'b0; bus.restart = 1'b0;
        model_clr = 1'b1; inject = 1'b0; src_zero = zero; raw = src_raw;
        tick(); tick();
        reset = 1'b0; model_clr = 1'b0; bus.enable = 1'b1;
    endtask

    // Timeline model: slip j lands at cycle 6j, lock at the given cycle.
    task automatic run_hunt(input int rot, input int exp_slips, input int exp_lock, input int ncyc);
        logic [7:0] prev_din;
        int p0, sc;
        logic exp_bs;
        start_hunt(rotl8(PAT, 8 - rot), 1'b0);
        obs();
        prev_din = bus.data_in;
        p0 = pulses;
        for (int c = 1; c <= ncyc; c++) begin
            tick(); obs();
            exp_bs = (c % 6 == 0) && (c / 6 >= 1) && (c / 6 <= exp_slips);
            sc = (c / 6 < exp_slips) ? c / 6 : exp_slips;
            check("bitslip", bus.bitslip, exp_bs);
            check("aligned", bus.aligned, c >= exp_lock);
            check("data_valid", bus.data_valid, c >= exp_lock);
            check("slip_count", bus.slip_count, sc);
            check("data_out", bus.data_out, prev_din);
            check("fail", bus.fail, 0);
            if (c >= exp_lock - 8 && c < exp_lock) check("state_check", dut.state == ST_CHECK, 1);
            if (c > exp_lock) check("valid_word", bus.data_out, PAT);
            prev_din = bus.data_in;
        end
        if (ncyc >= exp_lock) check("hunt_pulses", pulses - p0, exp_slips);
    endtask

    initial begin
        vec_t vecs[4];
        int p0, fail_bad, s;
        int seq[7];

        vecs[0] = '{0, 0, 13};
        vecs[1] = '{3, 3, 31};
        vecs[2] = '{1, 1, 19};
        vecs[3] = '{7, 7, 55};
        seq = '{1, 1, 1, 0, 1, 1, 1};

        // Reset state
        bus.enable = 1'b0; bus.restart = 1'b0;
        tick(); tick(); obs();
        check("rst_bitslip", bus.bitslip, 0);
        check("rst_aligned", bus.aligned, 0);
        check("rst_fail", bus.fail, 0);
        check("rst_slip_count", bus.slip_count, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_data_valid", bus.data_valid, 0);
        check("rst_state", dut.state == ST_IDLE, 1);

        for (int i = 0; i < 4; i++)
            run_hunt(vecs[i].rot, vecs[i].exp_slips, vecs[i].exp_lock, vecs[i].exp_lock + 4);

        for (int i = 0; i < 8; i++) begin
            s = $urandom_range(0, 7);
            run_hunt(s, s, 6 * s + 13, 6 * s + 17);
        end

        // Source never matches: 15 slips then sticky fail
        start_hunt(8'h00, 1'b1);
        obs();
        p0 = pulses;
        fail_bad = 0;
        for (int c = 1; c <= 196; c++) begin
            tick(); obs();
            if (c == 95) check("fail_early", bus.fail, 0);
            if (c >= 96 && bus.fail !== 1'b1) fail_bad++;
        end
        check("fail_pulses", pulses - p0, 15);
        check("fail_sticky", fail_bad, 0);
        check("fail_slip_count", bus.slip_count, 15);
        tick(); bus.restart = 1'b1; obs();
        check("fail_before_restart", bus.fail, 1);
        tick(); bus.restart = 1'b0; obs();
        check("restart_fail_clr", bus.fail, 0);
        check("restart_slip_clr", bus.slip_count, 0);
        for (int k = 2; k <= 6; k++) begin
            tick(); obs();
            if (k == 5) check("restart_no_slip", bus.bitslip, 0);
        end
        check("restart_slip", bus.bitslip, 1);
        check("restart_slip_count", bus.slip_count, 1);

        // Non-consecutive misses hold lock; four in a row drop it
        src_zero = 1'b0;
        run_hunt(0, 0, 13, 17);
        p0 = pulses;
        for (int k = 0; k < 7; k++) begin
            tick(); inject = seq[k][0]; obs();
            check("hold_lock", bus.aligned, 1);
        end
        tick(); inject = 1'b0; obs();
        check("hold_lock_end", bus.aligned, 1);
        for (int k = 0; k < 4; k++) begin
            tick(); inject = 1'b1; obs();
            check("unlock_pending", bus.aligned, 1);
        end
        tick(); inject = 1'b0; obs();
        check("unlock_aligned", bus.aligned, 0);
        check("unlock_state", dut.state == ST_SETTLE, 1);
        for (int k = 5; k <= 16; k++) begin
            tick(); obs();
            if (k == 15) check("relock_early", bus.aligned, 0);
        end
        check("relock", bus.aligned, 1);
        check("relock_pulses", pulses - p0, 0);
        check("relock_slip_count", bus.slip_count, 0);

        // Reset during SETTLE after two slips
        run_hunt(3, 3, 31, 14);
        check("pre_rst_slips", bus.slip_count, 2);
        tick(); reset = 1'b1; bus.enable = 1'b0; obs();
        tick(); reset = 1'b0; obs();
        check("midrst_bitslip", bus.bitslip, 0);
        check("midrst_slip_count", bus.slip_count, 0);
        check("midrst_aligned", bus.aligned, 0);
        check("midrst_data_out", bus.data_out, 0);
        check("midrst_state", dut.state == ST_IDLE, 1);
        p0 = pulses;
        repeat (20) begin tick(); obs(); end
        check("midrst_no_pulse", pulses - p0, 0);

        // Enable dropped while locked
        run_hunt(0, 0, 13, 17);
        tick(); bus.enable = 1'b0; obs();
        check("en_drop_still", bus.aligned, 1);
        tick(); obs();
        check("en_drop_aligned", bus.aligned, 0);
        check("en_drop_state", dut.state == ST_IDLE, 1);

        check("no_back_to_back", b2b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
